// File: rtl/d_mem_pkg.sv
// Shared types for the data-memory pipe: access size, per-request metadata,
// response payload and the load-data formatter used at the pipe tail.
package d_mem_pkg;

  localparam logic [31:0] ERR_PATTERN_DFLT = 32'hAAAA_AAAA;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       we;
    logic       uns;
    logic [1:0] size;
    logic [1:0] lane;
  } meta_t;

  // Lane select plus sign/zero extension; errors and stores override the data.
  function automatic rsp_t fmt_rsp(meta_t m, logic [31:0] raw, logic [31:0] err_pat);
    rsp_t        r;
    logic [31:0] sh;
    sh      = raw >> {m.lane, 3'b000};
    r.err   = m.err;
    r.rdata = raw;
    if (m.err) begin
      r.rdata = m.we ? 32'h0 : err_pat;
    end else if (m.we) begin
      r.rdata = 32'h0;
    end else begin
      case (m.size)
        SZ_B:    r.rdata = {{24{sh[7] & ~m.uns}}, sh[7:0]};
        SZ_H:    r.rdata = {{16{sh[15] & ~m.uns}}, sh[15:0]};
        default: r.rdata = raw;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/d_mem_pipe_if.sv
// Request/response handshake bundle between a load/store unit and d_mem_pipe.
interface d_mem_pipe_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/d_mem_rsp_fifo.sv
// Two-entry in-order response buffer; absorbs responses while the consumer stalls.
module d_mem_rsp_fifo
  import d_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output logic empty,
  output rsp_t head
);

  rsp_t       ent_q [2];
  rsp_t       ent_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
    if (push) ent_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign empty = (cnt_q == 2'd0);
  assign head  = ent_q[rd_ptr_q];

endmodule

// File: rtl/d_mem_pipe.sv
// Byte-addressed data memory with a valid/ready request pipe, RD_LAT-cycle
// array read, and at most two requests in flight (pipe plus response buffer).
module d_mem_pipe
  import d_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [31:0] ERR_PATTERN = ERR_PATTERN_DFLT
) (
  input logic         clk,
  input logic         rst_n,
  d_mem_pipe_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_rd_q;
  meta_t         s1_d, s1_q, tail_meta;
  logic [31:0]   tail_raw;
  logic [1:0]    out_d, out_q;
  logic          run_d, run_q;
  logic          req_ready, acc, drain, push, pop, fifo_empty, rsp_valid;
  logic          req_err, we_en;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [AW-1:0] idx;
  rsp_t          tail_rsp, head_rsp, out_rsp;

  always_comb begin
    idx       = bus.req_addr_i[AW+1:2];
    req_err   = ({2'b00, bus.req_addr_i[31:2]} >= DEPTH_WORDS);
    be        = 4'b0000;
    wdata_rep = bus.req_wdata_i;
    case (bus.req_size_i)
      SZ_B: begin
        be        = 4'b0001 << bus.req_addr_i[1:0];
        wdata_rep = {4{bus.req_wdata_i[7:0]}};
      end
      SZ_H: begin
        req_err   = req_err | bus.req_addr_i[0];
        be        = 4'b0011 << bus.req_addr_i[1:0];
        wdata_rep = {2{bus.req_wdata_i[15:0]}};
      end
      SZ_W: begin
        req_err = req_err | (bus.req_addr_i[1:0] != 2'b00);
        be      = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
    we_en = acc & bus.req_we_i & ~req_err;

    s1_d.valid = acc;
    s1_d.err   = req_err;
    s1_d.we    = bus.req_we_i;
    s1_d.uns   = bus.req_unsigned_i;
    s1_d.size  = bus.req_size_i;
    s1_d.lane  = bus.req_addr_i[1:0];
  end

  // Single-port array: one access per accept; byte enables avoid read-modify-write.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int b = 0; b < 4; b++)
        if (we_en && be[b]) mem[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      ram_rd_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      out_q <= 2'd0;
      run_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      out_q <= out_d;
      run_q <= run_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    meta_t       s2_q;
    logic [31:0] rd2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_q  <= '0;
        rd2_q <= '0;
      end else begin
        s2_q  <= s1_q;
        rd2_q <= ram_rd_q;
      end
    end
    assign tail_meta = s2_q;
    assign tail_raw  = rd2_q;
  end else begin : g_lat1
    assign tail_meta = s1_q;
    assign tail_raw  = ram_rd_q;
  end

  // The tail bypasses the buffer when it is empty and the consumer is ready;
  // a response being drained this cycle frees a slot for a new accept.
  always_comb begin
    tail_rsp  = fmt_rsp(tail_meta, tail_raw, ERR_PATTERN);
    rsp_valid = ~fifo_empty | tail_meta.valid;
    out_rsp   = fifo_empty ? tail_rsp : head_rsp;
    drain     = rsp_valid & bus.rsp_ready_i;
    push      = tail_meta.valid & ~(fifo_empty & bus.rsp_ready_i);
    pop       = ~fifo_empty & bus.rsp_ready_i;
    req_ready = run_q & ((out_q != 2'd2) | drain);
    acc       = bus.req_valid_i & req_ready;
    out_d     = out_q + 2'(acc) - 2'(drain);
    run_d     = 1'b1;
  end

  d_mem_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (tail_rsp),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (head_rsp)
  );

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_valid ? out_rsp.rdata : 32'h0;
  assign bus.rsp_err_o   = rsp_valid & out_rsp.err;

endmodule

// File: tb/tb_d_mem_pipe.sv
// Directed bench for d_mem_pipe: one instance at RD_LAT=1 and one at RD_LAT=2
// sharing request fields; sel chooses which instance sees req_valid.
module tb_d_mem_pipe;
  import d_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        we_r = 1'b0;
  logic [31:0] addr_r = '0;
  logic [1:0]  size_r = 2'b00;
  logic        uns_r = 1'b0;
  logic [31:0] wdata_r = '0;
  logic        rsp_ready = 1'b1;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  d_mem_pipe_if b1 ();
  d_mem_pipe_if b2 ();

  assign b1.req_valid_i    = valid & ~sel;
  assign b2.req_valid_i    = valid & sel;
  assign b1.req_we_i       = we_r;
  assign b2.req_we_i       = we_r;
  assign b1.req_addr_i     = addr_r;
  assign b2.req_addr_i     = addr_r;
  assign b1.req_size_i     = size_r;
  assign b2.req_size_i     = size_r;
  assign b1.req_unsigned_i = uns_r;
  assign b2.req_unsigned_i = uns_r;
  assign b1.req_wdata_i    = wdata_r;
  assign b2.req_wdata_i    = wdata_r;
  assign b1.rsp_ready_i    = rsp_ready;
  assign b2.rsp_ready_i    = rsp_ready;

  d_mem_pipe #(.RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  d_mem_pipe #(.RD_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  function automatic logic cur_ready();
    return sel ? b2.req_ready_o : b1.req_ready_o;
  endfunction
  function automatic logic cur_vld();
    return sel ? b2.rsp_valid_o : b1.rsp_valid_o;
  endfunction
  function automatic logic [31:0] cur_rdata();
    return sel ? b2.rsp_rdata_o : b1.rsp_rdata_o;
  endfunction
  function automatic logic cur_err();
    return sel ? b2.rsp_err_o : b1.rsp_err_o;
  endfunction

  // Issue one request with rsp_ready=1 and return its response.
  task automatic do_req(input logic s, input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    rd = 'x;
    er = 'x;
    @(negedge clk);
    sel = s; rsp_ready = 1'b1; valid = 1'b1;
    we_r = we; addr_r = a; size_r = sz; uns_r = u; wdata_r = wd;
    n = 0;
    while (cur_ready() !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL req_accept_timeout addr=%h", a);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (cur_vld() !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL rsp_timeout addr=%h", a);
      return;
    end
    rd = cur_rdata();
    er = cur_err();
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (b1.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", b1.rsp_valid_o); end
    total++; if (b1.rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", b1.rsp_rdata_o); end
    total++; if (b1.rsp_err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", b1.rsp_err_o); end
    total++; if (b1.req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", b1.req_ready_o); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (b1.req_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_rst got=%b exp=1", b1.req_ready_o); end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; logic er;
    do_req(0, 1, 32'h10, SZ_W, 0, 32'h1122_3344, rd, er);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL st_w_10 got=%h/%b exp=0/0", rd, er); end
    do_req(0, 0, 32'h13, SZ_B, 0, 32'h0, rd, er);
    total++; if (rd !== 32'h0000_0011 || er !== 1'b0) begin bad++; $display("FAIL ld_bs_13 got=%h/%b exp=00000011/0", rd, er); end
    do_req(0, 0, 32'h12, SZ_H, 1, 32'h0, rd, er);
    total++; if (rd !== 32'h0000_1122 || er !== 1'b0) begin bad++; $display("FAIL ld_hu_12 got=%h/%b exp=00001122/0", rd, er); end
    do_req(0, 0, 32'h10, SZ_W, 0, 32'h0, rd, er);
    total++; if (rd !== 32'h1122_3344) begin bad++; $display("FAIL ld_w_10 got=%h exp=11223344", rd); end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er;
    do_req(0, 1, 32'h20, SZ_W, 0, 32'h5566_7788, rd, er);
    do_req(0, 1, 32'h21, SZ_B, 0, 32'h0000_00F0, rd, er);
    do_req(0, 0, 32'h21, SZ_B, 0, 32'h0, rd, er);
    total++; if (rd !== 32'hFFFF_FFF0 || er !== 1'b0) begin bad++; $display("FAIL ld_bs_21 got=%h/%b exp=fffffff0/0", rd, er); end
    do_req(0, 0, 32'h21, SZ_B, 1, 32'h0, rd, er);
    total++; if (rd !== 32'h0000_00F0) begin bad++; $display("FAIL ld_bu_21 got=%h exp=000000f0", rd); end
    do_req(0, 0, 32'h20, SZ_W, 0, 32'h0, rd, er);
    total++; if (rd !== 32'h5566_F088) begin bad++; $display("FAIL ld_w_20 got=%h exp=5566f088", rd); end
    do_req(0, 1, 32'h22, SZ_H, 0, 32'h0000_BEEF, rd, er);
    do_req(0, 0, 32'h22, SZ_H, 0, 32'h0, rd, er);
    total++; if (rd !== 32'hFFFF_BEEF) begin bad++; $display("FAIL ld_hs_22 got=%h exp=ffffbeef", rd); end
    do_req(0, 0, 32'h23, SZ_B, 1, 32'h0, rd, er);
    total++; if (rd !== 32'h0000_00BE) begin bad++; $display("FAIL ld_bu_23 got=%h exp=000000be", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er;
    do_req(0, 1, 32'h0, SZ_W, 0, 32'h0BAD_F00D, rd, er);
    do_req(0, 1, 32'h4, SZ_W, 0, 32'hCAFE_F00D, rd, er);
    do_req(0, 0, 32'h6, SZ_W, 0, 32'h0, rd, er);
    total++; if (rd !== 32'hAAAA_AAAA || er !== 1'b1) begin bad++; $display("FAIL ld_misalign got=%h/%b exp=aaaaaaaa/1", rd, er); end
    do_req(0, 0, 32'h400, SZ_W, 0, 32'h0, rd, er);
    total++; if (rd !== 32'hAAAA_AAAA || er !== 1'b1) begin bad++; $display("FAIL ld_range got=%h/%b exp=aaaaaaaa/1", rd, er); end
    do_req(0, 1, 32'h6, SZ_W, 0, 32'hDEAD_BEEF, rd, er);
    total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL st_misalign got=%h/%b exp=0/1", rd, er); end
    do_req(0, 1, 32'h400, SZ_W, 0, 32'hDEAD_BEEF, rd, er);
    total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL st_range got=%h/%b exp=0/1", rd, er); end
    do_req(0, 0, 32'h4, SZ_W, 0, 32'h0, rd, er);
    total++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin bad++; $display("FAIL ld_w_4_kept got=%h/%b exp=cafef00d/0", rd, er); end
    do_req(0, 0, 32'h0, SZ_W, 0, 32'h0, rd, er);
    total++; if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin bad++; $display("FAIL ld_w_0_kept got=%h/%b exp=0badf00d/0", rd, er); end
    do_req(0, 0, 32'h8, 2'b11, 0, 32'h0, rd, er);
    total++; if (rd !== 32'hAAAA_AAAA || er !== 1'b1) begin bad++; $display("FAIL ld_size3 got=%h/%b exp=aaaaaaaa/1", rd, er); end
    do_req(0, 0, 32'h1, SZ_H, 0, 32'h0, rd, er);
    total++; if (rd !== 32'hAAAA_AAAA || er !== 1'b1) begin bad++; $display("FAIL ld_h_odd got=%h/%b exp=aaaaaaaa/1", rd, er); end
  endtask

  task automatic test_store_then_load();
    @(negedge clk);
    sel = 0; rsp_ready = 1; valid = 1;
    we_r = 1; addr_r = 32'h60; size_r = SZ_W; uns_r = 0; wdata_r = 32'h7777_7777;
    total++; if (b1.req_ready_o !== 1'b1) begin bad++; $display("FAIL adj_ready0 got=%b exp=1", b1.req_ready_o); end
    @(negedge clk);
    we_r = 0;
    total++; if (b1.rsp_valid_o !== 1'b1 || b1.rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL adj_st_rsp got=%b/%h exp=1/0", b1.rsp_valid_o, b1.rsp_rdata_o); end
    total++; if (b1.req_ready_o !== 1'b1) begin bad++; $display("FAIL adj_ready1 got=%b exp=1", b1.req_ready_o); end
    @(negedge clk);
    valid = 0;
    total++; if (b1.rsp_valid_o !== 1'b1 || b1.rsp_rdata_o !== 32'h7777_7777) begin bad++; $display("FAIL adj_ld_rsp got=%b/%h exp=1/77777777", b1.rsp_valid_o, b1.rsp_rdata_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; logic rdy;
    int idx, nacc;
    do_req(0, 1, 32'h30, SZ_W, 0, 32'hA1A2_A3A4, rd, er);
    @(negedge clk);
    sel = 0; rsp_ready = 0; idx = 0; nacc = 0;
    for (int c = 0; c < 6; c++) begin
      valid = 1; we_r = 0;
      case (idx)
        0:       begin addr_r = 32'h30; size_r = SZ_B; uns_r = 1; end
        1:       begin addr_r = 32'h32; size_r = SZ_H; uns_r = 0; end
        default: begin addr_r = 32'h30; size_r = SZ_W; uns_r = 0; end
      endcase
      rdy = b1.req_ready_o;
      @(posedge clk);
      if (rdy) begin nacc++; idx++; end
      @(negedge clk);
    end
    total++; if (nacc != 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", nacc); end
    total++; if (b1.req_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", b1.req_ready_o); end
    valid = 0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (b1.rsp_valid_o !== 1'b1 || b1.rsp_rdata_o !== 32'h0000_00A4 || b1.rsp_err_o !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/000000a4/0", c, b1.rsp_valid_o, b1.rsp_rdata_o, b1.rsp_err_o);
      end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    total++; if (b1.rsp_valid_o !== 1'b1 || b1.rsp_rdata_o !== 32'hFFFF_A1A2) begin bad++; $display("FAIL bp_second got=%b/%h exp=1/ffffa1a2", b1.rsp_valid_o, b1.rsp_rdata_o); end
    @(negedge clk);
    total++; if (b1.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", b1.rsp_valid_o); end
    total++; if (b1.req_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", b1.req_ready_o); end
  endtask

  task automatic test_back_to_back(input logic s, input int lat);
    logic [31:0] rd; logic er; logic exp_v;
    for (int i = 0; i < 4; i++) do_req(s, 1, 32'(32'h40 + 4 * i), SZ_W, 0, 32'(32'h10 * (i + 1)), rd, er);
    @(negedge clk);
    sel = s; rsp_ready = 1; valid = 1; we_r = 0; addr_r = 32'h40; size_r = SZ_W; uns_r = 0;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        total++; if (cur_ready() !== 1'b1) begin bad++; $display("FAIL b2b_lat%0d_ready%0d got=%b exp=1", lat, k, cur_ready()); end
      end
      @(posedge clk);
      @(negedge clk);
      if (k < 3) addr_r = 32'(32'h40 + 4 * (k + 1));
      else valid = 0;
      exp_v = (k >= lat - 1) && (k <= lat + 2);
      total++;
      if (cur_vld() !== exp_v || (exp_v && cur_rdata() !== 32'(32'h10 * (k - lat + 2)))) begin
        bad++; $display("FAIL b2b_lat%0d_k%0d got=%b/%h exp=%b/%h", lat, k, cur_vld(), cur_rdata(), exp_v, 32'(32'h10 * (k - lat + 2)));
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; logic er;
    do_req(0, 1, 32'h50, SZ_W, 0, 32'h5A5A_1234, rd, er);
    @(negedge clk);
    sel = 0; rsp_ready = 0; valid = 1; we_r = 0; addr_r = 32'h50; size_r = SZ_W; uns_r = 0;
    for (int i = 0; i < 2; i++) begin
      total++; if (b1.req_ready_o !== 1'b1) begin bad++; $display("FAIL rm_ready%0d got=%b exp=1", i, b1.req_ready_o); end
      @(posedge clk);
      #1;
    end
    valid = 0;
    @(negedge clk);
    total++; if (b1.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL rm_pending got=%b exp=1", b1.rsp_valid_o); end
    #2 rst_n = 0;
    #1;
    total++; if (b1.rsp_valid_o !== 1'b0 || b1.rsp_rdata_o !== 32'h0 || b1.rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL rm_async got=%b/%h/%b exp=0/0/0", b1.rsp_valid_o, b1.rsp_rdata_o, b1.rsp_err_o);
    end
    total++; if (b1.req_ready_o !== 1'b0) begin bad++; $display("FAIL rm_ready_in_rst got=%b exp=0", b1.req_ready_o); end
    repeat (2) @(negedge clk);
    rst_n = 1; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (b1.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rm_stale%0d got=%b exp=0", i, b1.rsp_valid_o); end
    end
    do_req(0, 0, 32'h50, SZ_W, 0, 32'h0, rd, er);
    total++; if (rd !== 32'h5A5A_1234 || er !== 1'b0) begin bad++; $display("FAIL rm_persist got=%h/%b exp=5a5a1234/0", rd, er); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_errors();
    test_store_then_load();
    test_backpressure();
    test_back_to_back(1'b0, 1);
    test_back_to_back(1'b1, 2);
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/d_mem_pipe.md
D_MEM_PIPE -- requirements
Module: d_mem_pipe

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words; legal range is a power of two, 16..65536.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning array read latency in cycles; legal values are 1 or 2.
REQ-003 SHALL have parameter ERR_PATTERN, default 32'hAAAAAAAA, meaning the read data returned on an error.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port req_valid_i, input, 1, meaning a request is present.
REQ-007 SHALL have port req_ready_o, output, 1, meaning a request can be accepted.
REQ-008 SHALL have port req_we_i, input, 1, where 1 is a store and 0 is a load.
REQ-009 SHALL have port req_addr_i, input, 32, the byte address.
REQ-010 SHALL have port req_size_i, input, 2, encoded as 00 byte, 01 half, 10 word; 11 is illegal.
REQ-011 SHALL have port req_unsigned_i, input, 1, where 1 selects zero-extension of loads.
REQ-012 SHALL have port req_wdata_i, input, 32, store data right-aligned (bits [7:0], [15:0] or [31:0]).
REQ-013 SHALL have port rsp_valid_o, output, 1, meaning a response is present.
REQ-014 SHALL have port rsp_ready_i, input, 1, meaning the consumer accepts the response.
REQ-015 SHALL have port rsp_rdata_o, output, 32, the extended load data; it is 0 for stores.
REQ-016 SHALL have port rsp_err_o, output, 1, flagging a misaligned, out-of-range or illegal-size request.

Function
REQ-017 SHALL accept a request on a rising edge when req_valid_i and req_ready_o are both 1; each accepted request produces exactly one response, in order.
REQ-018 SHALL limit outstanding requests (in pipeline plus response FIFO) to 2; req_ready_o = (outstanding < 2), registered or combinational, with no dependence on req_valid_i.
REQ-019 SHALL present the response of a request accepted at edge N no earlier than the cycle after edge N+RD_LAT-1, i.e. latency is exactly RD_LAT cycles when unstalled.
REQ-020 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-021 SHALL flag misalignment when: half with addr[0]=1, or word with addr[1:0]≠0.
REQ-022 SHALL flag out-of-range when addr[31:2] ≥ DEPTH_WORDS.
REQ-023 SHALL treat size 11 as an error.
REQ-024 SHALL, on any error, suppress the write, return ERR_PATTERN as rdata for loads and 0 for stores, and set rsp_err_o=1.
REQ-025 SHALL commit a store at its accept edge, with the byte mask derived from size and addr[1:0] and data replicated to the selected lanes.
REQ-026 SHALL extract load data by lane from addr[1:0], then sign- or zero-extend per req_unsigned_i; word loads are unmodified.
REQ-027 SHALL return the new data on a load accepted the cycle after a store to the same word (no stale read).
REQ-028 SHALL allow back-to-back accepts with rsp_ready_i held at 1, giving a throughput of 1 request per cycle.

Reset
REQ-029 SHALL, while rst_n=0, force rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, outstanding=0 and all pipeline valids=0, and hold req_ready_o=0.
REQ-030 SHALL drop in-flight requests and their responses when reset is asserted mid-operation; completed stores persist.
REQ-031 SHALL NOT reset memory array contents.

Structure
REQ-032 SHALL place the following in shared package d_mem_pkg: the size enum (SZ_B, SZ_H, SZ_W), the response struct {rdata, err} and the default ERR_PATTERN.
REQ-033 SHALL instantiate one sub-module, d_mem_rsp_fifo: a 2-entry in-order response buffer with async active-low reset.
REQ-034 SHALL infer the array as a single-port block RAM with byte enables; there SHALL be no read-modify-write.

Verification
REQ-035 SHALL cover: store word 0x11223344 @0x10, then load byte-signed @0x13 and load half-unsigned @0x12 -> rdata 0x00000011, then 0x00001122, err=0.
REQ-036 SHALL cover: store byte 0xF0 @0x21, then load byte-signed @0x21 -> rdata 0xFFFFFFF0; load word @0x20 shows only lane 1 changed.
REQ-037 SHALL cover: load word @0x6 and @(DEPTH_WORDS*4) -> rdata 0xAAAAAAAA, err=1; a store to the same addresses leaves memory unchanged.
REQ-038 SHALL cover: rsp_ready_i=0 with 3 requests issued -> exactly 2 accepted, req_ready_o=0; on release, responses drain in order with data held stable.
REQ-039 SHALL cover: RD_LAT=2, 4 back-to-back loads with rsp_ready_i=1 -> responses on 4 consecutive cycles starting 2 cycles after the first accept.
REQ-040 SHALL cover: rst_n asserted with 2 requests outstanding -> rsp_valid_o=0 immediately; after release no stale response appears, and a store made before the reset reads back intact.
